parameter_command_decoder: RTL and testbench



---
 rtl/parameter_cmd_pkg.sv | 26 ++
 rtl/frame_timeout_counter.sv | 31 +++
 rtl/parameter_command_decoder.sv | 154 +++++++++++++++
 tb/tb_parameter_command_decoder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/parameter_cmd_pkg.sv
// Shared opcodes, FSM state encoding and frame-length lookup for the
// parameter command decoder.
package parameter_cmd_pkg;

    localparam logic [3:0] OP_ACT   = 4'h1;
    localparam logic [3:0] OP_DENSE = 4'h2;
    localparam logic [3:0] OP_COST  = 4'h3;
    localparam logic [3:0] OP_LR    = 4'h4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_CHECKSUM,
        ST_EMIT
    } state_t;

    // Payload byte count for an opcode; 0 marks an opcode we do not decode.
    function automatic logic [1:0] payload_len(input logic [3:0] opcode);
        case (opcode)
            OP_ACT, OP_DENSE, OP_COST: payload_len = 2'd1;
            OP_LR:                     payload_len = 2'd2;
            default:                   payload_len = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/frame_timeout_counter.sv
// Counts consecutive stalled cycles inside a frame; expired fires in the
// stalled cycle that would bring the count up to timeout_cycles.
module frame_timeout_counter #(
    parameter int timeout_cycles = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(timeout_cycles + 1);
    localparam logic [CW-1:0] LAST = CW'(timeout_cycles - 1);

    logic [CW-1:0] count_q;

    assign expired = enable && (count_q == LAST);

    // NOTE: state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/parameter_command_decoder.sv
// Parses header/payload/checksum frames from a byte stream and commits the
// addressed parameter with a one-cycle strobe, or pulses error on rejection.
module parameter_command_decoder #(
    parameter int act_type_size      = 4,
    parameter int dense_type_size    = 4,
    parameter int cost_type_size     = 8,
    parameter int learning_rate_size = 16,
    parameter int timeout_cycles     = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [act_type_size-1:0]      out_act_type,
    output logic [dense_type_size-1:0]    out_dense_type,
    output logic [cost_type_size-1:0]     out_cost_type,
    output logic [learning_rate_size-1:0] out_learning_rate,
    output logic                          update_act_type,
    output logic                          update_dense_type,
    output logic                          update_cost_type,
    output logic                          update_learning_rate,
    output logic                          error,
    output logic                          busy
);

    import parameter_cmd_pkg::*;

    state_t      state_q, state_d;
    logic [3:0]  opcode_q;
    logic        byte_cnt_q;
    logic [15:0] shift_q;
    logic [7:0]  xor_q;
    logic        emit_ok_q, emit_err_q;
    logic        accept, set_ok, set_err;
    logic        timer_enable, timer_expired;
    logic [1:0]  hdr_len;

    assign in_ready = rst_n && (state_q != ST_EMIT);
    assign accept   = in_valid && in_ready;
    assign hdr_len  = payload_len(in_data[7:4]);
    assign busy     = (state_q != ST_IDLE);

    frame_timeout_counter #(
        .timeout_cycles(timeout_cycles)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .enable (timer_enable),
        .expired(timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every output of this block is defaulted first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        set_ok       = 1'b0;
        set_err      = 1'b0;
        timer_enable = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (hdr_len == 2'd0) begin
                        state_d = ST_EMIT;
                        set_err = 1'b1;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                timer_enable = !accept;
                if (timer_expired) begin
                    state_d = ST_EMIT;
                    set_err = 1'b1;
                end else if (accept && !byte_cnt_q) begin
                    state_d = ST_CHECKSUM;
                end
            end
            ST_CHECKSUM: begin
                timer_enable = !accept;
                if (timer_expired) begin
                    state_d = ST_EMIT;
                    set_err = 1'b1;
                end else if (accept) begin
                    state_d = ST_EMIT;
                    set_ok  = (in_data == xor_q);
                    set_err = (in_data != xor_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame datapath: payload shift register and running checksum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q   <= '0;
            byte_cnt_q <= 1'b0;
            shift_q    <= '0;
            xor_q      <= '0;
        end else if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    opcode_q   <= in_data[7:4];
                    xor_q      <= in_data;
                    byte_cnt_q <= (hdr_len == 2'd2);
                end
                ST_PAYLOAD: begin
                    shift_q    <= {shift_q[7:0], in_data};
                    xor_q      <= xor_q ^ in_data;
                    byte_cnt_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Outputs load at the edge into EMIT so the value and strobe coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            emit_ok_q         <= 1'b0;
            emit_err_q        <= 1'b0;
            out_act_type      <= '0;
            out_dense_type    <= '0;
            out_cost_type     <= '0;
            out_learning_rate <= '0;
        end else begin
            emit_ok_q  <= set_ok;
            emit_err_q <= set_err;
            if (set_ok) begin
                case (opcode_q)
                    OP_ACT:   out_act_type      <= shift_q[act_type_size-1:0];
                    OP_DENSE: out_dense_type    <= shift_q[dense_type_size-1:0];
                    OP_COST:  out_cost_type     <= shift_q[cost_type_size-1:0];
                    OP_LR:    out_learning_rate <= shift_q[learning_rate_size-1:0];
                    default: ;
                endcase
            end
        end
    end

    assign update_act_type      = emit_ok_q && (opcode_q == OP_ACT);
    assign update_dense_type    = emit_ok_q && (opcode_q == OP_DENSE);
    assign update_cost_type     = emit_ok_q && (opcode_q == OP_COST);
    assign update_learning_rate = emit_ok_q && (opcode_q == OP_LR);
    assign error                = emit_err_q;

endmodule

// File: tb/tb_parameter_command_decoder.sv
// Directed bench for parameter_command_decoder: good, bad, invalid, stalled
// and reset-interrupted frames against hand-computed results.
module tb_parameter_command_decoder;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  out_act_type;
    logic [3:0]  out_dense_type;
    logic [7:0]  out_cost_type;
    logic [15:0] out_learning_rate;
    logic        update_act_type, update_dense_type;
    logic        update_cost_type, update_learning_rate;
    logic        error, busy;
    logic [4:0]  evec;

    int checks = 0;
    int failures = 0;
    int strobe_pulses = 0;
    int err_pulses = 0;
    int multi_hot = 0;

    parameter_command_decoder dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .in_data             (in_data),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .out_act_type        (out_act_type),
        .out_dense_type      (out_dense_type),
        .out_cost_type       (out_cost_type),
        .out_learning_rate   (out_learning_rate),
        .update_act_type     (update_act_type),
        .update_dense_type   (update_dense_type),
        .update_cost_type    (update_cost_type),
        .update_learning_rate(update_learning_rate),
        .error               (error),
        .busy                (busy)
    );

    // {error, lr, cost, dense, act}
    assign evec = {error, update_learning_rate, update_cost_type,
                   update_dense_type, update_act_type};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        strobe_pulses += $countones(evec[3:0]);
        err_pulses    += int'(evec[4]);
        if ($countones(evec) > 1) multi_hot++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Offers one byte and returns 1 time unit after the edge that accepts it.
    task automatic send_byte(input logic [7:0] b);
        int budget;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        budget   = 0;
        while (!in_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) check("ready_wait", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b0, b1, b2, b3, input int n);
        send_byte(b0);
        if (n > 1) send_byte(b1);
        if (n > 2) send_byte(b2);
        if (n > 3) send_byte(b3);
    endtask

    // Called in the EMIT cycle; also confirms the pulse lasts one cycle only.
    task automatic check_emit(input string tag, input logic [4:0] exp_vec);
        check({tag, "_pulse"}, 32'(evec), 32'(exp_vec));
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_after"}, 32'(evec), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] act, dense,
                                 input logic [7:0] cost, input logic [15:0] lr);
        check({tag, "_act"}, 32'(out_act_type), 32'(act));
        check({tag, "_dense"}, 32'(out_dense_type), 32'(dense));
        check({tag, "_cost"}, 32'(out_cost_type), 32'(cost));
        check({tag, "_lr"}, 32'(out_learning_rate), 32'(lr));
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #12;
        check_outputs("rst", 4'h0, 4'h0, 8'h00, 16'h0000);
        check("rst_pulses", 32'(evec), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_ready", 32'(in_ready), 32'd1);

        // Activation type: checksum 0x10^0x05 = 0x15
        send_frame(8'h10, 8'h05, 8'h15, 8'h00, 3);
        check_outputs("act", 4'h5, 4'h0, 8'h00, 16'h0000);
        check_emit("act", 5'b00001);

        // Learning rate, MSB first: 0x40^0x12^0x34 = 0x66
        send_frame(8'h40, 8'h12, 8'h34, 8'h66, 4);
        check_outputs("lr", 4'h5, 4'h0, 8'h00, 16'h1234);
        check_emit("lr", 5'b01000);

        // Good cost frame, then a bad checksum must leave it alone
        send_frame(8'h30, 8'h7E, 8'h4E, 8'h00, 3);
        check_outputs("cost", 4'h5, 4'h0, 8'h7E, 16'h1234);
        check_emit("cost", 5'b00100);
        send_frame(8'h30, 8'hAB, 8'h00, 8'h00, 3);
        check_outputs("badck", 4'h5, 4'h0, 8'h7E, 16'h1234);
        check_emit("badck", 5'b10000);

        // Invalid opcode rejected right after the header
        send_byte(8'h70);
        check_emit("badop", 5'b10000);
        send_frame(8'h20, 8'h09, 8'h29, 8'h00, 3);
        check_outputs("dense", 4'h5, 4'h9, 8'h7E, 16'h1234);
        check_emit("dense", 5'b00010);

        // Stall after header: error follows the 255th idle cycle
        send_byte(8'h20);
        repeat (254) @(posedge clk);
        #1;
        check("tmo_early", 32'(evec), 32'd0);
        check("tmo_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check_emit("tmo", 5'b10000);
        check_outputs("tmo", 4'h5, 4'h9, 8'h7E, 16'h1234);
        send_frame(8'h10, 8'h0A, 8'h1A, 8'h00, 3);
        check_outputs("post_tmo", 4'hA, 4'h9, 8'h7E, 16'h1234);
        check_emit("post_tmo", 5'b00001);

        // Reset in the middle of a learning-rate frame
        send_frame(8'h40, 8'h12, 8'h00, 8'h00, 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs("midrst", 4'h0, 4'h0, 8'h00, 16'h0000);
        check("midrst_pulses", 32'(evec), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'h10, 8'h03, 8'h13, 8'h00, 3);
        check_outputs("after_rst", 4'h3, 4'h0, 8'h00, 16'h0000);
        check_emit("after_rst", 5'b00001);

        @(negedge clk);
        check("total_strobes", 32'(strobe_pulses), 32'd6);
        check("total_errors", 32'(err_pulses), 32'd3);
        check("one_hot", 32'(multi_hot), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
